// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_pkg
// Purpose : Shared constants for the pipeline hazard controller.
// Revision: 1.0
// ============================================================================
package hazard_pkg;

    localparam int          PIPE_DEPTH = 3;
    localparam int          NUM_REGS   = 16;
    localparam logic [3:0]  COND_AL    = 4'hE;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/sb_counter.sv
`default_nettype none
// ============================================================================
// Module  : sb_counter
// Purpose : 2-bit scoreboard countdown with load, hold and floor at zero.
// Revision: 1.0
// ============================================================================
module sb_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       load,
    input  logic [1:0] load_val,
    output logic [1:0] count
);

    logic [1:0] r_count;

    // Priority: hold (memory freeze) > load (new issue) > decrement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 2'd0;
        end else if (hold) begin
            r_count <= r_count;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != 2'd0) begin
            r_count <= r_count - 2'd1;
        end
    end

    assign count = r_count;

endmodule : sb_counter
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Purpose : Scoreboard-based RAW/flag hazard detection, stall/flush control.
// Revision: 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int PIPE_DEPTH = hazard_pkg::PIPE_DEPTH,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic             id_wb_en,
    input  logic [3:0]       id_dest,
    input  logic             id_s,
    input  logic [3:0]       id_cond,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             hazard,
    output logic             stall_if,
    output logic             stall_id,
    output logic             freeze,
    output logic             flush,
    output logic [15:0]      busy_map,
    output logic [CNT_W-1:0] stall_cnt
);

    import hazard_pkg::*;

    localparam logic [1:0]       c_wb_load  = 2'(PIPE_DEPTH);
    localparam logic [1:0]       c_sr_load  = 2'd1;
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    logic [1:0]          w_reg_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_reg_load;
    logic [1:0]          w_sr_cnt;
    logic                w_raw;
    logic                w_flag_haz;
    logic                w_hazard;
    logic                w_stall;
    logic                w_flush;
    logic                w_issue;
    logic [CNT_W-1:0]    r_stall_cnt;

    // Checks use the current counter state, so an instruction never waits on itself.
    assign w_raw      = id_valid & (w_busy[src1] | (two_src & w_busy[src2]));
    assign w_flag_haz = id_valid & (id_cond != COND_AL) & (w_sr_cnt != 2'd0);
    assign w_hazard   = (w_raw | w_flag_haz) & ~branch_taken;
    assign w_stall    = w_hazard | mem_busy;
    assign w_flush    = branch_taken & ~mem_busy;
    assign w_issue    = id_valid & ~w_hazard & ~mem_busy & ~w_flush;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_sb
            assign w_reg_load[gi] = w_issue & id_wb_en & (id_dest == 4'(gi));

            sb_counter u_cnt (
                .clk      (clk),
                .rst      (rst),
                .hold     (mem_busy),
                .load     (w_reg_load[gi]),
                .load_val (c_wb_load),
                .count    (w_reg_cnt[gi])
            );

            assign w_busy[gi] = (w_reg_cnt[gi] != 2'd0);
        end
    endgenerate

    // Flags become usable one cycle after the setting instruction leaves EX.
    sb_counter u_sr_cnt (
        .clk      (clk),
        .rst      (rst),
        .hold     (mem_busy),
        .load     (w_issue & id_s),
        .load_val (c_sr_load),
        .count    (w_sr_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign hazard    = w_hazard;
    assign stall_if  = w_stall;
    assign stall_id  = w_stall;
    assign freeze    = mem_busy;
    assign flush     = w_flush;
    assign busy_map  = w_busy;
    assign stall_cnt = r_stall_cnt;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Purpose : Directed scoreboard bench for pipe_hazard_ctrl.
// Revision: 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [3:0]  src1 = 4'd0;
    logic [3:0]  src2 = 4'd0;
    logic        two_src = 1'b0;
    logic        id_wb_en = 1'b0;
    logic [3:0]  id_dest = 4'd0;
    logic        id_s = 1'b0;
    logic [3:0]  id_cond = 4'hE;
    logic        branch_taken = 1'b0;
    logic        mem_busy = 1'b0;
    logic        hazard;
    logic        stall_if;
    logic        stall_id;
    logic        freeze;
    logic        flush;
    logic [15:0] busy_map;
    logic [15:0] stall_cnt;

    typedef struct packed {
        logic        haz;
        logic        flsh;
        logic        mb;
        logic [15:0] busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    pipe_hazard_ctrl #(.PIPE_DEPTH(3), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .src1         (src1),
        .src2         (src2),
        .two_src      (two_src),
        .id_wb_en     (id_wb_en),
        .id_dest      (id_dest),
        .id_s         (id_s),
        .id_cond      (id_cond),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .hazard       (hazard),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .freeze       (freeze),
        .flush        (flush),
        .busy_map     (busy_map),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    // One entry per cycle: inputs driven just after posedge, expected response queued.
    task automatic step(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic wb, input logic [3:0] dest,
                        input logic s, input logic [3:0] cond, input logic br,
                        input logic mb, input logic eh, input logic ef,
                        input logic [15:0] eb, input logic [15:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        id_valid = v; src1 = s1; src2 = s2; two_src = two; id_wb_en = wb;
        id_dest = dest; id_s = s; id_cond = cond; branch_taken = br; mem_busy = mb;
        e.haz = eh; e.flsh = ef; e.mb = mb; e.busy = eb; e.cnt = ec;
        q.push_back(e);
    endtask

    task automatic idle(input logic [15:0] eb, input logic [15:0] ec);
        step(0, 0, 0, 0, 0, 0, 0, 4'hE, 0, 0, 0, 0, eb, ec);
    endtask

    // Monitor: compares the DUT on the falling edge against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("hazard",    {15'd0, hazard},   {15'd0, e.haz});
                chk("stall_if",  {15'd0, stall_if}, {15'd0, e.haz | e.mb});
                chk("stall_id",  {15'd0, stall_id}, {15'd0, e.haz | e.mb});
                chk("freeze",    {15'd0, freeze},   {15'd0, e.mb});
                chk("flush",     {15'd0, flush},    {15'd0, e.flsh});
                chk("busy_map",  busy_map,          e.busy);
                chk("stall_cnt", stall_cnt,         e.cnt);
            end
        end
    end

    initial begin
        int wait_cyc;
        #2;
        chk("rst_busy_map",  busy_map,  16'h0000);
        chk("rst_stall_cnt", stall_cnt, 16'h0000);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;

        // RAW on r3: three stall cycles, then issue
        step(1, 1, 2, 1, 1, 3, 0, 4'hE, 0, 0, 0, 0, 16'h0000, 0);
        step(1, 3, 4, 1, 1, 6, 0, 4'hE, 0, 0, 1, 0, 16'h0008, 0);
        step(1, 3, 4, 1, 1, 6, 0, 4'hE, 0, 0, 1, 0, 16'h0008, 1);
        step(1, 3, 4, 1, 1, 6, 0, 4'hE, 0, 0, 1, 0, 16'h0008, 2);
        step(1, 3, 4, 1, 1, 6, 0, 4'hE, 0, 0, 0, 0, 16'h0000, 3);
        idle(16'h0040, 3);
        idle(16'h0040, 3);
        idle(16'h0040, 3);
        idle(16'h0000, 3);

        // Flag hazard: conditional after CMP stalls once; AL does not
        step(1, 1, 0, 0, 0, 0, 1, 4'hE, 0, 0, 0, 0, 16'h0000, 3);
        step(1, 2, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 16'h0000, 3);
        step(1, 2, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 4);
        step(1, 1, 0, 0, 0, 0, 1, 4'hE, 0, 0, 0, 0, 16'h0000, 4);
        step(1, 2, 0, 0, 0, 0, 0, 4'hE, 0, 0, 0, 0, 16'h0000, 4);
        idle(16'h0000, 4);

        // Memory freeze holds the scoreboard for five cycles
        step(1, 1, 0, 0, 1, 5, 0, 4'hE, 0, 0, 0, 0, 16'h0000, 4);
        for (int k = 0; k < 5; k++)
            step(1, 5, 0, 0, 0, 0, 0, 4'hE, 0, 1, 1, 0, 16'h0020, 16'(4 + k));
        step(1, 5, 0, 0, 0, 0, 0, 4'hE, 0, 0, 1, 0, 16'h0020, 9);
        step(1, 5, 0, 0, 0, 0, 0, 4'hE, 0, 0, 1, 0, 16'h0020, 10);
        step(1, 5, 0, 0, 0, 0, 0, 4'hE, 0, 0, 1, 0, 16'h0020, 11);
        step(1, 5, 0, 0, 0, 0, 0, 4'hE, 0, 0, 0, 0, 16'h0000, 12);
        idle(16'h0000, 12);

        // Taken branch over a dependent instruction, then during a freeze
        step(1, 1, 0, 0, 1, 7, 0, 4'hE, 0, 0, 0, 0, 16'h0000, 12);
        step(1, 7, 0, 0, 1, 8, 0, 4'hE, 1, 0, 0, 1, 16'h0080, 12);
        idle(16'h0080, 12);
        step(1, 7, 0, 0, 1, 9, 0, 4'hE, 1, 1, 0, 0, 16'h0080, 12);
        step(1, 7, 0, 0, 1, 9, 0, 4'hE, 1, 1, 0, 0, 16'h0080, 13);
        step(1, 7, 0, 0, 1, 9, 0, 4'hE, 1, 0, 0, 1, 16'h0080, 14);
        idle(16'h0000, 14);

        // Back-to-back writes to r5 reload the countdown
        step(1, 0, 0, 0, 1, 5, 0, 4'hE, 0, 0, 0, 0, 16'h0000, 14);
        step(1, 0, 0, 0, 1, 5, 0, 4'hE, 0, 0, 0, 0, 16'h0020, 14);
        idle(16'h0020, 14);
        idle(16'h0020, 14);
        idle(16'h0020, 14);
        idle(16'h0000, 14);

        // Destination equal to both sources does not self-stall
        step(1, 4, 4, 1, 1, 4, 0, 4'hE, 0, 0, 0, 0, 16'h0000, 14);
        idle(16'h0010, 14);

        // Build busy_map = 0028, then reset asynchronously mid-cycle
        step(1, 0, 0, 0, 1, 3, 0, 4'hE, 0, 0, 0, 0, 16'h0010, 14);
        step(1, 0, 0, 0, 1, 5, 0, 4'hE, 0, 0, 0, 0, 16'h0018, 14);
        idle(16'h0028, 14);
        #6 rst = 1'b0;
        #1;
        chk("async_busy_map",  busy_map,  16'h0000);
        chk("async_stall_cnt", stall_cnt, 16'h0000);
        #1 rst = 1'b1;
        step(1, 3, 5, 1, 0, 0, 0, 4'hE, 0, 0, 0, 0, 16'h0000, 0);
        idle(16'h0000, 0);

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
